// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared constants, state encoding and address-legality helper
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_DEFAULT   = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_ADEL         = 5'd4;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic addr_bad(input logic [31:0] a,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (a[1:0] != 2'b00) || (a < base) || (a > top);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_next_mux.sv
// ============================================================================
// fetch_unit_pc_next_mux : next-PC priority select (exc > eret > branch > PC+4)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit_pc_next_mux
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        npc_sel,
  input  logic [31:0] epc,
  input  logic [31:0] npc_target,
  input  logic [31:0] pc,
  output logic [31:0] pc_next
);

  always_comb begin
    if (exc_req) begin
      pc_next = EXC_VEC;
    end else if (eret_req) begin
      pc_next = epc;
    end else if (npc_sel) begin
      pc_next = npc_target;
    end else begin
      pc_next = pc + 32'd4;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : F-stage PC owner, IM request FSM, AdEL detection and redirects
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_TOP   = IM_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        is_bj_D,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ready,
  output logic [31:0] InstrF,
  output logic [31:0] PC_4F,
  output logic [4:0]  ExcCodeF,
  output logic        if_bdF,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic [4:0]   exc_q, exc_d;
  logic [31:0]  pc_next;
  logic         redirect;
  logic         bad;
  logic         req;

  assign redirect = exc_req | eret_req;
  assign bad      = addr_bad(pc_q, IM_BASE, IM_TOP);

  fetch_unit_pc_next_mux #(
    .EXC_VEC    (EXC_VEC)
  ) u_pc_next_mux (
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .npc_sel    (npc_sel),
    .epc        (epc),
    .npc_target (npc_target),
    .pc         (pc_q),
    .pc_next    (pc_next)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ibuf_d  = ibuf_q;
    exc_d   = exc_q;
    req     = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bad) begin
          ibuf_d  = '0;
          exc_d   = EXC_ADEL;
          state_d = S_VALID;
        end else begin
          req    = 1'b1;
          addr_d = pc_q;
          exc_d  = '0;
          if (im_ready) begin
            ibuf_d  = im_rdata;
            state_d = S_VALID;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (im_ready) begin
          ibuf_d  = im_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d    = pc_next;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        req = 1'b1;
        if (im_ready) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect abandons any outstanding read; its response must still be consumed.
    if (redirect) begin
      pc_d  = pc_next;
      exc_d = '0;
      if (state_q != S_DRAIN) begin
        state_d = (req && !im_ready) ? S_DRAIN : S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ibuf_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ibuf_q  <= ibuf_d;
      exc_q   <= exc_d;
    end
  end

  assign im_req     = req & ~reset;
  assign im_addr    = ((state_q == S_DRAIN) ? addr_q : pc_q) & ~32'd3;
  assign InstrF     = reset ? 32'd0 : ibuf_q;
  assign ExcCodeF   = reset ? 5'd0 : exc_q;
  assign PC_4F      = (reset ? RESET_PC : pc_q) + 32'd4;
  assign fetch_busy = reset | (state_q != S_VALID) | redirect;
  assign if_bdF     = is_bj_D & (state_q == S_VALID) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : scenario tasks plus randomized fetches against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        npc_sel = 1'b0;
  logic [31:0] npc_target = 32'd0;
  logic        is_bj_D = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ready;
  logic [31:0] InstrF;
  logic [31:0] PC_4F;
  logic [4:0]  ExcCodeF;
  logic        if_bdF;
  logic        fetch_busy;

  int lat = 0;
  int wcnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .npc_sel    (npc_sel),
    .npc_target (npc_target),
    .is_bj_D    (is_bj_D),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .im_ready   (im_ready),
    .InstrF     (InstrF),
    .PC_4F      (PC_4F),
    .ExcCodeF   (ExcCodeF),
    .if_bdF     (if_bdF),
    .fetch_busy (fetch_busy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3c010001;
    return {a[15:0] ^ 16'hbeef, ~a[15:0]};
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFF);
  endfunction

  // Instruction memory: answers a request once it has been held for 'lat' cycles.
  assign im_ready = im_req && (wcnt >= lat);
  assign im_rdata = word_at(im_addr);
  always @(posedge clk) begin
    if (reset || !im_req || im_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Called just after a negedge in the request cycle for 'pc'; returns at the
  // negedge of the next request cycle with the model's next PC.
  task automatic fetch_one(input logic [31:0] pc, input int lt, input int st, input bit br,
                           input logic [31:0] tgt, input bit bj, output logic [31:0] npc);
    bit          bad;
    logic [31:0] exp_i;
    logic [4:0]  exp_e;
    logic        exp_req;
    int          exp_busy;
    int          busy;
    bad      = is_bad(pc);
    exp_i    = bad ? 32'd0 : word_at(pc);
    exp_e    = bad ? 5'd4 : 5'd0;
    exp_req  = bad ? 1'b0 : 1'b1;
    exp_busy = bad ? 1 : lt + 1;
    lat      = lt;
    busy     = 0;
    #1;
    n_tests++;
    if (im_req !== exp_req || (!bad && im_addr !== pc)) begin
      n_fail++;
      $display("FAIL issue pc=%h: im_req=%b im_addr=%h, required im_req=%b im_addr=%h",
               pc, im_req, im_addr, exp_req, pc);
    end
    while (fetch_busy === 1'b1 && busy < 20) begin
      if (busy > 0 && !bad) begin
        n_tests++;
        if (im_req !== 1'b1 || im_addr !== pc) begin
          n_fail++;
          $display("FAIL wait_hold pc=%h: im_req=%b im_addr=%h, required 1/%h",
                   pc, im_req, im_addr, pc);
        end
      end
      busy++;
      @(negedge clk); #1;
    end
    n_tests++;
    if (busy != exp_busy) begin
      n_fail++;
      $display("FAIL latency pc=%h: busy cycles=%0d, required %0d", pc, busy, exp_busy);
    end
    n_tests++;
    if (InstrF !== exp_i || ExcCodeF !== exp_e || PC_4F !== pc + 32'd4 || im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL deliver pc=%h: InstrF=%h ExcCodeF=%0d PC_4F=%h im_req=%b, required %h %0d %h 0",
               pc, InstrF, ExcCodeF, PC_4F, im_req, exp_i, exp_e, pc + 32'd4);
    end
    for (int i = 0; i < st; i++) begin
      stall = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (fetch_busy !== 1'b0 || im_req !== 1'b0 || InstrF !== exp_i || PC_4F !== pc + 32'd4) begin
        n_fail++;
        $display("FAIL stall_hold pc=%h: busy=%b im_req=%b InstrF=%h PC_4F=%h, required 0 0 %h %h",
                 pc, fetch_busy, im_req, InstrF, PC_4F, exp_i, pc + 32'd4);
      end
    end
    stall      = 1'b0;
    npc_sel    = br;
    npc_target = tgt;
    is_bj_D    = bj;
    #1;
    n_tests++;
    if (if_bdF !== bj) begin
      n_fail++;
      $display("FAIL if_bd pc=%h: if_bdF=%b, required %b", pc, if_bdF, bj);
    end
    npc = br ? tgt : pc + 32'd4;
    @(negedge clk);
    npc_sel = 1'b0;
    is_bj_D = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    lat     = 0;
    is_bj_D = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (im_req !== 1'b0 || fetch_busy !== 1'b1 || if_bdF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: im_req=%b fetch_busy=%b if_bdF=%b, required 0 1 0",
               im_req, fetch_busy, if_bdF);
    end
    n_tests++;
    if (InstrF !== 32'd0 || PC_4F !== 32'h0000_3004 || ExcCodeF !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: InstrF=%h PC_4F=%h ExcCodeF=%0d, required 0 00003004 0",
               InstrF, PC_4F, ExcCodeF);
    end
    is_bj_D = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_zero_wait();
    fetch_one(32'h0000_3000, 0, 0, 1'b0, 32'd0, 1'b0, mpc);
  endtask

  task automatic test_wait();
    fetch_one(mpc, 3, 0, 1'b0, 32'd0, 1'b0, mpc);
  endtask

  task automatic test_stall_branch();
    fetch_one(mpc, 0, 5, 1'b1, 32'h0000_3100, 1'b1, mpc);
  endtask

  task automatic test_exc_drain();
    int g;
    fetch_one(mpc, 1, 0, 1'b1, 32'h0000_3010, 1'b0, mpc);
    lat = 3;
    @(negedge clk); #1;
    exc_req = 1'b1;
    #1;
    n_tests++;
    if (fetch_busy !== 1'b1 || im_addr !== 32'h0000_3010) begin
      n_fail++;
      $display("FAIL exc_in_wait: fetch_busy=%b im_addr=%h, required 1 00003010", fetch_busy, im_addr);
    end
    @(negedge clk);
    exc_req = 1'b0;
    #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h0000_3010 || fetch_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold: im_req=%b im_addr=%h busy=%b, required 1 00003010 1",
               im_req, im_addr, fetch_busy);
    end
    g = 0;
    while (!(im_req === 1'b1 && im_addr === 32'h0000_4180) && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    n_tests++;
    if (g >= 20) begin
      n_fail++;
      $display("FAIL exc_vector: im_addr=%h im_req=%b, required 00004180 1", im_addr, im_req);
    end
    fetch_one(32'h0000_4180, 3, 0, 1'b0, 32'd0, 1'b0, mpc);
    lat      = 0;
    exc_req  = 1'b1;
    eret_req = 1'b1;
    epc      = 32'h0000_5000;
    #1;
    n_tests++;
    if (fetch_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_busy: fetch_busy=%b, required 1", fetch_busy);
    end
    @(negedge clk);
    exc_req  = 1'b0;
    eret_req = 1'b0;
    fetch_one(32'h0000_4180, 0, 0, 1'b0, 32'd0, 1'b0, mpc);
  endtask

  task automatic test_eret_bad();
    logic [31:0] targets [2];
    targets[0] = 32'h0000_3002;
    targets[1] = 32'h0000_7000;
    for (int i = 0; i < 2; i++) begin
      lat      = 0;
      eret_req = 1'b1;
      epc      = targets[i];
      @(negedge clk);
      eret_req = 1'b0;
      fetch_one(targets[i], 0, 1, 1'b0, 32'd0, 1'b0, mpc);
    end
  endtask

  task automatic test_random();
    int          lt;
    int          st;
    bit          br;
    bit          bj;
    logic [31:0] tgt;
    for (int n = 0; n < 40; n++) begin
      lt = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 2));
      br = ($urandom_range(0, 3) == 0) || is_bad(mpc);
      bj = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) tgt = $urandom;
      else tgt = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
      fetch_one(mpc, lt, st, br, tgt, bj, mpc);
    end
  endtask

  task automatic test_reset_mid();
    fetch_one(mpc, 0, 0, 1'b1, 32'h0000_3200, 1'b0, mpc);
    lat = 3;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (im_req !== 1'b0 || fetch_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: im_req=%b fetch_busy=%b, required 0 1", im_req, fetch_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    fetch_one(32'h0000_3000, 0, 0, 1'b0, 32'd0, 1'b0, mpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait();
    test_stall_branch();
    test_exc_drain();
    test_eret_bad();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
